rename_ctrl: RTL and testbench

//  Owns the busy/rename-tag table beside the architectural register file and sequences its write port.

---
 rtl/rename_ctrl.sv | 159 +++++++++++++++
 tb/tb_rename_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_ctrl.sv
// Busy/rename-tag table for the architectural register file. It also drives the value-array write
// port from ROB commits and discards every outstanding rename on a mispredict flush.
module rename_ctrl #(
    parameter int REG_NUM   = 32,
    parameter int REG_IDX_W = 5,
    parameter int ROB_IDX_W = 4,
    parameter int DATA_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 flush,
    input  logic                 issue_valid,
    input  logic [REG_IDX_W-1:0] issue_rd,
    input  logic [ROB_IDX_W-1:0] issue_tag,
    output logic                 issue_ready,
    input  logic                 commit_valid,
    input  logic [REG_IDX_W-1:0] commit_rd,
    input  logic [ROB_IDX_W-1:0] commit_tag,
    input  logic [DATA_W-1:0]    commit_value,
    output logic                 commit_ready,
    input  logic [REG_IDX_W-1:0] rs1_index,
    output logic                 rs1_busy,
    output logic [ROB_IDX_W-1:0] rs1_tag,
    output logic                 rs1_fwd,
    input  logic [REG_IDX_W-1:0] rs2_index,
    output logic                 rs2_busy,
    output logic [ROB_IDX_W-1:0] rs2_tag,
    output logic                 rs2_fwd,
    output logic                 rf_we,
    output logic [REG_IDX_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]    rf_wdata,
    output logic [5:0]           busy_count
);

    typedef enum logic {RUN, CLEAR} state_t;

    state_t                 state_reg, state_next;
    logic [REG_NUM-1:0]     busy_reg, busy_next;
    logic [ROB_IDX_W-1:0]   tag_reg  [REG_NUM];
    logic [ROB_IDX_W-1:0]   tag_next [REG_NUM];
    logic [REG_NUM-1:0]     hit_issue, hit_clear;
    logic [5:0]             count_reg, count_next;
    logic                   rf_we_reg;
    logic [REG_IDX_W-1:0]   rf_waddr_reg;
    logic [DATA_W-1:0]      rf_wdata_reg;
    logic                   clear_req;
    logic                   issue_acc, commit_acc, commit_wr;

    always_comb begin
        state_next   = state_reg;
        issue_ready  = 1'b0;
        commit_ready = 1'b0;
        clear_req    = 1'b0;
        case (state_reg)
            RUN: begin
                issue_ready  = rdy;
                commit_ready = rdy;
                if (rdy && flush) state_next = CLEAR;
            end
            CLEAR: begin
                clear_req = rdy;
                if (rdy) state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    // An issue in the flush cycle belongs to the wrong path and is dropped; x0 never becomes busy.
    assign issue_acc  = issue_valid && issue_ready && !flush && (issue_rd != '0);
    assign commit_acc = commit_valid && commit_ready;
    assign commit_wr  = commit_acc && (commit_rd != '0);

    genvar gi;
    generate
        for (gi = 0; gi < REG_NUM; gi++) begin : g_reg
            assign hit_issue[gi] = issue_acc && (issue_rd == REG_IDX_W'(gi));
            assign hit_clear[gi] = commit_acc && (commit_rd == REG_IDX_W'(gi))
                                   && busy_reg[gi] && (tag_reg[gi] == commit_tag);
            // Issue takes priority so a same-cycle commit to the old rename cannot free the new one.
            assign busy_next[gi] = clear_req     ? 1'b0 :
                                   hit_issue[gi] ? 1'b1 :
                                   hit_clear[gi] ? 1'b0 : busy_reg[gi];
            assign tag_next[gi]  = clear_req     ? '0 :
                                   hit_issue[gi] ? issue_tag : tag_reg[gi];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) tag_reg[gi] <= '0;
                else     tag_reg[gi] <= tag_next[gi];
            end
        end
    endgenerate

    always_comb begin
        count_next = '0;
        for (int i = 0; i < REG_NUM; i++) begin
            count_next = count_next + 6'(busy_next[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= RUN;
            busy_reg  <= '0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= busy_next;
            count_reg <= count_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we_reg    <= 1'b0;
            rf_waddr_reg <= '0;
            rf_wdata_reg <= '0;
        end else if (rdy) begin
            rf_we_reg <= commit_wr;
            if (commit_wr) begin
                rf_waddr_reg <= commit_rd;
                rf_wdata_reg <= commit_value;
            end
        end
    end

    logic [REG_IDX_W-1:0] lk_idx  [2];
    logic                 lk_busy [2];
    logic                 lk_fwd  [2];
    logic [ROB_IDX_W-1:0] lk_tag  [2];

    assign lk_idx[0] = rs1_index;
    assign lk_idx[1] = rs2_index;

    genvar pi;
    generate
        for (pi = 0; pi < 2; pi++) begin : g_lookup
            logic nz;
            assign nz          = (lk_idx[pi] != '0);
            // A commit retiring the producer this cycle lets the reader take commit_value directly.
            assign lk_fwd[pi]  = nz && commit_acc && (commit_rd == lk_idx[pi])
                                 && busy_reg[lk_idx[pi]] && (tag_reg[lk_idx[pi]] == commit_tag);
            assign lk_busy[pi] = nz && busy_reg[lk_idx[pi]] && !lk_fwd[pi];
            assign lk_tag[pi]  = tag_reg[lk_idx[pi]];
        end
    endgenerate

    assign rs1_busy   = lk_busy[0];
    assign rs1_tag    = lk_tag[0];
    assign rs1_fwd    = lk_fwd[0];
    assign rs2_busy   = lk_busy[1];
    assign rs2_tag    = lk_tag[1];
    assign rs2_fwd    = lk_fwd[1];
    assign rf_we      = rf_we_reg;
    assign rf_waddr   = rf_waddr_reg;
    assign rf_wdata   = rf_wdata_reg;
    assign busy_count = count_reg;

endmodule

// File: tb/tb_rename_ctrl.sv
// Bench for rename_ctrl: scenario tasks drive the decoder/ROB side, expected value-array writes
// are queued at drive time and matched against rf_* by a monitor one cycle later.
module tb_rename_ctrl;

    logic        clk = 1'b0;
    logic        rst, rdy, flush;
    logic        issue_valid, issue_ready;
    logic [4:0]  issue_rd;
    logic [3:0]  issue_tag;
    logic        commit_valid, commit_ready;
    logic [4:0]  commit_rd;
    logic [3:0]  commit_tag;
    logic [31:0] commit_value;
    logic [4:0]  rs1_index, rs2_index;
    logic        rs1_busy, rs1_fwd, rs2_busy, rs2_fwd;
    logic [3:0]  rs1_tag, rs2_tag;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [5:0]  busy_count;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic rdy_edge = 1'b0;

    typedef struct {
        int          due;
        logic [4:0]  rd;
        logic [31:0] val;
    } wr_t;
    wr_t exp_q[$];

    rename_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_tag(issue_tag),
        .issue_ready(issue_ready),
        .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_tag(commit_tag),
        .commit_value(commit_value), .commit_ready(commit_ready),
        .rs1_index(rs1_index), .rs1_busy(rs1_busy), .rs1_tag(rs1_tag), .rs1_fwd(rs1_fwd),
        .rs2_index(rs2_index), .rs2_busy(rs2_busy), .rs2_tag(rs2_tag), .rs2_fwd(rs2_fwd),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy_count(busy_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rdy_edge <= rdy;
    end

    // Write-port monitor: an expected write must appear exactly on its due cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            n_checks++;
            if (rf_we !== 1'b1 || rf_waddr !== exp_q[0].rd || rf_wdata !== exp_q[0].val) begin
                n_fail++;
                $display("FAIL rf_write: got we=%0b addr=%0d data=%h, want we=1 addr=%0d data=%h",
                         rf_we, rf_waddr, rf_wdata, exp_q[0].rd, exp_q[0].val);
            end else begin
                $display("rf write x%0d = %h (cycle %0d)", rf_waddr, rf_wdata, cyc);
            end
            void'(exp_q.pop_front());
        end else if (rdy_edge && rf_we !== 1'b0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rf_spurious: got we=%0b addr=%0d, want we=0 (cycle %0d)", rf_we, rf_waddr, cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        issue_valid  = 1'b0;
        commit_valid = 1'b0;
        flush        = 1'b0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [3:0] tag);
        issue_valid = 1'b1;
        issue_rd    = rd;
        issue_tag   = tag;
    endtask

    task automatic commit(input logic [4:0] rd, input logic [3:0] tag, input logic [31:0] val,
                          input bit expect_wr);
        wr_t e;
        commit_valid = 1'b1;
        commit_rd    = rd;
        commit_tag   = tag;
        commit_value = val;
        if (expect_wr) begin
            e.due = cyc + 1;
            e.rd  = rd;
            e.val = val;
            exp_q.push_back(e);
        end
        $display("commit x%0d tag %0d val %h (cycle %0d)", rd, tag, val, cyc);
    endtask

    task automatic test_reset();
        n_checks++;
        if (busy_count !== 6'd0 || rf_we !== 1'b0 || issue_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: got count=%0d we=%0b iready=%0b, want 0 0 1",
                     busy_count, rf_we, issue_ready);
        end
        issue(5, 1);
        commit(6, 0, 32'h0000_1234, 1);
        step();
        clr();
        rs1_index = 5;
        @(negedge clk);
        n_checks++;
        if (busy_count !== 6'd1 || rs1_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: got count=%0d busy=%0b, want 1 1", busy_count, rs1_busy);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (busy_count !== 6'd0 || rs1_busy !== 1'b0 || rf_we !== 1'b0 ||
            rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
            n_fail++;
            $display("FAIL async_reset: got count=%0d busy=%0b we=%0b addr=%0d data=%h, want all 0",
                     busy_count, rs1_busy, rf_we, rf_waddr, rf_wdata);
        end
        step();
        rst = 1'b0;
    endtask

    task automatic test_issue_commit();
        rs1_index = 5;
        issue(5, 3);
        step();
        clr();
        @(negedge clk);
        n_checks++;
        if (busy_count !== 6'd1 || rs1_busy !== 1'b1 || rs1_tag !== 4'd3) begin
            n_fail++;
            $display("FAIL issue_x5: got count=%0d busy=%0b tag=%0d, want 1 1 3", busy_count, rs1_busy, rs1_tag);
        end
        step();
        commit(5, 3, 32'hDEAD_BEEF, 1);
        step();
        clr();
        @(negedge clk);
        n_checks++;
        if (busy_count !== 6'd0 || rs1_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL commit_x5: got count=%0d busy=%0b, want 0 0", busy_count, rs1_busy);
        end
        step();
    endtask

    task automatic test_stale_commit();
        rs1_index = 7;
        issue(7, 2);
        step();
        issue(7, 9);
        step();
        clr();
        commit(7, 2, 32'h0000_0077, 1);
        step();
        clr();
        @(negedge clk);
        n_checks++;
        if (busy_count !== 6'd1 || rs1_busy !== 1'b1 || rs1_tag !== 4'd9) begin
            n_fail++;
            $display("FAIL stale_commit: got count=%0d busy=%0b tag=%0d, want 1 1 9", busy_count, rs1_busy, rs1_tag);
        end
        step();
        commit(7, 9, 32'h0000_0079, 1);
        step();
        clr();
        @(negedge clk);
        n_checks++;
        if (busy_count !== 6'd0 || rs1_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stale_cleanup: got count=%0d busy=%0b, want 0 0", busy_count, rs1_busy);
        end
        step();
    endtask

    task automatic test_same_cycle();
        rs2_index = 4;
        issue(4, 1);
        step();
        issue(4, 6);
        commit(4, 1, 32'h0000_0044, 1);
        step();
        clr();
        @(negedge clk);
        n_checks++;
        if (busy_count !== 6'd1 || rs2_busy !== 1'b1 || rs2_tag !== 4'd6) begin
            n_fail++;
            $display("FAIL same_cycle: got count=%0d busy=%0b tag=%0d, want 1 1 6", busy_count, rs2_busy, rs2_tag);
        end
        step();
        commit(4, 6, 32'h0000_0046, 1);
        step();
        clr();
        @(negedge clk);
        n_checks++;
        if (busy_count !== 6'd0) begin
            n_fail++;
            $display("FAIL same_cycle_cleanup: got count=%0d, want 0", busy_count);
        end
        step();
    endtask

    task automatic test_bypass();
        issue(9, 4);
        step();
        clr();
        rs1_index = 9;
        rs2_index = 0;
        commit(9, 4, 32'h0000_0099, 1);
        #1;
        n_checks++;
        if (rs1_busy !== 1'b0 || rs1_fwd !== 1'b1 || rs1_tag !== 4'd4) begin
            n_fail++;
            $display("FAIL bypass: got busy=%0b fwd=%0b tag=%0d, want 0 1 4", rs1_busy, rs1_fwd, rs1_tag);
        end
        n_checks++;
        if (rs2_busy !== 1'b0 || rs2_fwd !== 1'b0) begin
            n_fail++;
            $display("FAIL lookup_x0: got busy=%0b fwd=%0b, want 0 0", rs2_busy, rs2_fwd);
        end
        step();
        clr();
        @(negedge clk);
        n_checks++;
        if (busy_count !== 6'd0 || rs1_fwd !== 1'b0 || rs1_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bypass_after: got count=%0d fwd=%0b busy=%0b, want 0 0 0", busy_count, rs1_fwd, rs1_busy);
        end
        step();
    endtask

    task automatic test_x0_and_freeze();
        issue(0, 5);
        commit(0, 5, 32'hFFFF_FFFF, 0);
        step();
        clr();
        rs1_index = 0;
        @(negedge clk);
        n_checks++;
        if (busy_count !== 6'd0 || rs1_busy !== 1'b0 || rs1_tag !== 4'd0) begin
            n_fail++;
            $display("FAIL x0_ignored: got count=%0d busy=%0b tag=%0d, want 0 0 0", busy_count, rs1_busy, rs1_tag);
        end
        step();
        rdy = 1'b0;
        issue(10, 5);
        rs1_index = 10;
        #1;
        n_checks++;
        if (issue_ready !== 1'b0 || commit_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL freeze_ready: got iready=%0b cready=%0b, want 0 0", issue_ready, commit_ready);
        end
        step();
        step();
        clr();
        n_checks++;
        if (busy_count !== 6'd0 || rs1_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL freeze_state: got count=%0d busy=%0b, want 0 0", busy_count, rs1_busy);
        end
        rdy = 1'b1;
        step();
    endtask

    task automatic test_flush(input int stall);
        issue(1, 1);
        step();
        issue(2, 2);
        step();
        issue(3, 3);
        step();
        clr();
        n_checks++;
        if (busy_count !== 6'd3) begin
            n_fail++;
            $display("FAIL flush_setup: got count=%0d, want 3", busy_count);
        end
        flush = 1'b1;
        commit(3, 3, 32'h0000_0033, 1);
        issue(8, 8);
        step();
        clr();
        for (int i = 0; i <= stall; i++) begin
            rdy = (i == stall);
            #1;
            n_checks++;
            if (issue_ready !== 1'b0 || commit_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL clear_ready: got iready=%0b cready=%0b, want 0 0 (stall %0d)",
                         issue_ready, commit_ready, i);
            end
            step();
        end
        rs1_index = 8;
        rs2_index = 1;
        #1;
        n_checks++;
        if (busy_count !== 6'd0 || rs1_busy !== 1'b0 || rs2_busy !== 1'b0 || rs2_tag !== 4'd0 ||
            issue_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL after_flush: got count=%0d b8=%0b b1=%0b t1=%0d iready=%0b, want 0 0 0 0 1",
                     busy_count, rs1_busy, rs2_busy, rs2_tag, issue_ready);
        end
        step();
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; flush = 1'b0;
        issue_valid = 1'b0; issue_rd = '0; issue_tag = '0;
        commit_valid = 1'b0; commit_rd = '0; commit_tag = '0; commit_value = '0;
        rs1_index = '0; rs2_index = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        step();
        test_reset();
        test_issue_commit();
        test_stale_commit();
        test_same_cycle();
        test_bypass();
        test_x0_and_freeze();
        test_flush(0);
        test_flush(2);
        repeat (2) step();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_writes: got %0d unmatched, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
